// File: rtl/bus_timer_pkg.sv
// Shared timer constants: register offsets, CTRL bit positions, MODE and FSM encodings.
package bus_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN      = 32'd0;
    localparam int unsigned CTRL_MODE_LO = 32'd1;
    localparam int unsigned CTRL_MODE_HI = 32'd2;
    localparam int unsigned CTRL_IM      = 32'd3;
    localparam int unsigned CTRL_PSC_LO  = 32'd4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Reserved MODE codes fall back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Tick generator for the countdown: one tick every psc+1 clocks.
// Only compiled when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_r;

    assign tick = (cnt_r == psc);

    // Free-running divider, restarted by clr and after every tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {PSC_W{1'b0}};
        end else if (clr || tick) begin
            cnt_r <= {PSC_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(PSC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`endif

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the CPU data bus (CTRL / PRESET / COUNT registers).
// Optional clock prescaler in CTRL[7:4] is enabled by defining TIMER_PRESCALE_EN.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic             en_r;
    logic             im_r;
    logic             pend_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] preset_r;
    logic [CNT_W-1:0] count_r;
    logic [PSC_W-1:0] psc_s;
    logic             ctrl_wr_s;
    logic             preset_wr_s;
    logic             tick_s;
    logic [31:0]      ctrl_rd_s;
    logic             unused_s;

    assign ctrl_wr_s   = sel & we & (addr[3:2] == TMR_CTRL);
    assign preset_wr_s = sel & we & (addr[3:2] == TMR_PRESET);
    assign unused_s    = ^{addr[31:4], addr[1:0]};
    assign irq         = im_r & pend_r;

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc_r;
    logic             clr_s;

    assign clr_s = (state_r == ST_LOAD) | ~en_r;
    assign psc_s = psc_r;

    // Prescaler field of CTRL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_r <= {PSC_W{1'b0}};
        end else if (ctrl_wr_s) begin
            psc_r <= wdata[CTRL_PSC_LO +: PSC_W];
        end
    end

    timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .psc   (psc_s),
        .tick  (tick_s)
    );
`else
    assign psc_s  = {PSC_W{1'b0}};
    assign tick_s = 1'b1;
`endif

    // CTRL fields; a CPU write takes priority over the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r   <= 1'b0;
            mode_r <= MODE_ONESHOT;
            im_r   <= 1'b0;
        end else if (ctrl_wr_s) begin
            en_r   <= wdata[CTRL_EN];
            mode_r <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im_r   <= wdata[CTRL_IM];
        end else if ((state_r == ST_INT) && !is_reload(mode_r)) begin
            en_r   <= 1'b0;
        end
    end

    // Pending flag: setting in INT beats a same-cycle CTRL write clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r <= 1'b0;
        end else if (state_r == ST_INT) begin
            pend_r <= 1'b1;
        end else if (ctrl_wr_s) begin
            pend_r <= 1'b0;
        end
    end

    // PRESET only feeds LOAD, so writes never disturb a running count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_r <= {CNT_W{1'b0}};
        end else if (preset_wr_s) begin
            preset_r <= wdata[CNT_W-1:0];
        end
    end

    // Countdown sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_r) begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_r <= (preset_r == {CNT_W{1'b0}}) ? CNT_ONE : preset_r;
                    state_r <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en_r) begin
                        state_r <= ST_IDLE;
                    end else if (tick_s) begin
                        if (count_r > CNT_ONE) begin
                            count_r <= count_r - CNT_ONE;
                        end else begin
                            count_r <= {CNT_W{1'b0}};
                            state_r <= ST_INT;
                        end
                    end
                end
                ST_INT: begin
                    state_r <= is_reload(mode_r) ? ST_LOAD : ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // CTRL read image; unused upper bits read as zero.
    always_comb begin
        ctrl_rd_s = 32'd0;
        ctrl_rd_s[CTRL_EN] = en_r;
        ctrl_rd_s[CTRL_MODE_HI:CTRL_MODE_LO] = mode_r;
        ctrl_rd_s[CTRL_IM] = im_r;
        ctrl_rd_s[CTRL_PSC_LO +: PSC_W] = psc_s;
    end

    // Combinational bus read mux.
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr[3:2])
                TMR_CTRL:   rdata = ctrl_rd_s;
                TMR_PRESET: rdata[CNT_W-1:0] = preset_r;
                TMR_COUNT:  rdata[CNT_W-1:0] = count_r;
                default:    rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: a run-phase reference model predicts every cycle's rdata/irq.
`timescale 1ns/1ps
module tb_bus_timer;

`ifdef TIMER_PRESCALE_EN
    localparam bit HAS_PSC = 1'b1;
`else
    localparam bit HAS_PSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    bus_timer dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t  q[$];
    exp_t  e_mon;
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "init";

    // Reference model: a run is described by its origin edge (EN seen in IDLE) and
    // the run length P; everything else follows from the elapsed edge count.
    bit        m_en, m_im, m_pend, m_run;
    bit [1:0]  m_mode;
    bit [3:0]  m_psc;
    bit [31:0] m_preset, m_count;
    int        m_p, m_o, t;

    task automatic model_reset();
        m_en = 0; m_im = 0; m_pend = 0; m_run = 0; m_mode = 0; m_psc = 0;
        m_preset = 0; m_count = 0; m_p = 1; m_o = 0;
    endtask

    task automatic model_edge();
        int j, s;
        bit set_now;
        set_now = 0;
        t++;
        s = HAS_PSC ? int'(m_psc) + 1 : 1;
        if (m_run) begin
            j = t - m_o;
            if (j == 2) begin
                m_p = (m_preset == 0) ? 1 : int'(m_preset);
                m_count = 32'(m_p);
            end else if (j >= 3 && j <= 2 + s * m_p) begin
                if (!m_en) m_run = 0;
                else if ((j - 2) % s == 0) m_count = 32'(m_p - (j - 2) / s);
            end else if (j == 3 + s * m_p) begin
                m_pend = 1;
                set_now = 1;
                if (m_mode == 2'b01) m_o = t - 1;
                else begin
                    m_en = 0;
                    m_run = 0;
                end
            end
        end
        if (sel && we) begin
            case (addr[3:2])
                2'd0: begin
                    m_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3]; m_psc = wdata[7:4];
                    if (!set_now) m_pend = 0;
                    if (m_en && !m_run) begin
                        m_run = 1;
                        m_o = t;
                    end
                end
                2'd1: m_preset = wdata;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_rd();
        if (!sel) return 32'd0;
        case (addr[3:2])
            2'd0: return {24'd0, (HAS_PSC ? m_psc : 4'd0), m_im, m_mode, m_en};
            2'd1: return m_preset;
            2'd2: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one bus cycle; the model absorbs the edge that committed the previous cycle.
    task automatic bus(input bit s, input bit [31:0] a, input bit w, input bit [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        sel = s; addr = a; we = w; wdata = d;
        e.rd = model_rd();
        e.irq = m_im & m_pend;
        e.tag = cur_tag;
        q.push_back(e);
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d);
        bus(1'b1, a, 1'b1, d);
    endtask

    task automatic rd(input bit [31:0] a);
        bus(1'b1, a, 1'b0, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        q.delete();
        model_reset();
        sel = 1'b1; addr = 32'h8; we = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rdata=%h irq=%b, expected rdata=00000000 irq=0", rdata, irq);
        end
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        reset = 1'b1;
    endtask

    // Monitor: pop one expectation per cycle and compare against the bus outputs.
    always @(negedge clk) begin
        if (reset && q.size() > 0) begin
            e_mon = q.pop_front();
            checks++;
            if (rdata !== e_mon.rd || irq !== e_mon.irq) begin
                errors++;
                $display("FAIL %s: rdata=%h irq=%b, expected rdata=%h irq=%b",
                         e_mon.tag, rdata, irq, e_mon.rd, e_mon.irq);
            end
        end
    end

    initial begin
        t = 0;
        model_reset();
        do_reset();

        cur_tag = "reset_mid";
        wr(32'h4, 32'd5); wr(32'h0, 32'h9);
        repeat (4) rd(32'h8);
        do_reset();
        cur_tag = "after_reset";
        for (int a = 0; a < 4; a++) rd(32'(a * 4));
        idle(3); rd(32'h8); rd(32'h0);

        cur_tag = "oneshot";
        wr(32'h4, 32'd5); wr(32'h0, 32'h9);
        repeat (10) rd(32'h8);
        rd(32'h0); idle(3); wr(32'h0, 32'h8); rd(32'h0); idle(2);

        cur_tag = "autoreload";
        wr(32'h4, 32'd3); wr(32'h0, 32'hB);
        repeat (14) rd(32'h8);
        wr(32'h0, 32'h0);
        repeat (6) rd(32'h8);

        cur_tag = "preset_midrun";
        wr(32'h4, 32'd3); wr(32'h0, 32'hB); rd(32'h8); rd(32'h8);
        wr(32'h4, 32'd100); wr(32'h8, 32'hFFFF);
        repeat (12) rd(32'h8);
        rd(32'h4); wr(32'h0, 32'h0); idle(5); rd(32'h8);

        cur_tag = "preset_zero";
        wr(32'h4, 32'd0); wr(32'h0, 32'h1);
        repeat (5) rd(32'h8);
        rd(32'h0); wr(32'h0, 32'h8); rd(32'h0); idle(2);

        cur_tag = "rearm_at_int";
        wr(32'h4, 32'd2); wr(32'h0, 32'h9);
        repeat (4) rd(32'h8);
        wr(32'h0, 32'h9);
        repeat (8) rd(32'h8);
        rd(32'h0); wr(32'h0, 32'h0); idle(4);

        cur_tag = "prescale";
        wr(32'h4, 32'd2); wr(32'h0, 32'h39); rd(32'h0);
        repeat (14) rd(32'h8);
        rd(32'h0); wr(32'h0, 32'h0); idle(4);

        cur_tag = "random";
        repeat (120) begin
            bit [3:0] psc;
            psc = 4'($urandom_range(0, 3));
            wr(32'h4, 32'($urandom_range(0, 6)));
            wr(32'h0, {24'd0, psc, 1'($urandom), 2'($urandom), 1'b1});
            repeat ($urandom_range(4, 30)) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 55)      rd($urandom);
                else if (r < 65) bus(1'b0, $urandom, 1'($urandom), $urandom);
                else if (r < 75) wr({$urandom_range(0, 255), 4'h4}, 32'($urandom_range(0, 6)));
                else if (r < 82) wr({$urandom_range(0, 255), 4'h8}, $urandom);
                else if (r < 88) wr({$urandom_range(0, 255), 4'hC}, $urandom);
                else if (r < 96) wr(32'h0, {24'd0, psc, 1'($urandom), 2'($urandom), 1'($urandom)});
                else             wr(32'h0, 32'h0);
            end
            wr(32'h0, 32'h0);
            idle(4);
            rd(32'h8);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
